// File: rtl/cmul_pkg.sv
// Shared constants and helpers for the complex-multiplier flow controller.
package cmul_pkg;

   localparam int unsigned CMUL_LATENCY = 2;
   localparam int unsigned CMUL_DEPTH   = 4;
   localparam int unsigned CMUL_DATA_W  = 32;

   // Width of a counter that must hold 0..n inclusive.
   function automatic int unsigned clog2_plus1(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) <= 64'(n)) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/cmul_res_fifo.sv
// Result buffer for the multiplier datapath; head reads as zero while empty.
module cmul_res_fifo
   import cmul_pkg::*;
#(
   parameter int unsigned DEPTH  = CMUL_DEPTH,
   parameter int unsigned DATA_W = CMUL_DATA_W
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            sw_rst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [DATA_W-1:0]               wdata,
   output logic [DATA_W-1:0]               rdata,
   output logic [clog2_plus1(DEPTH)-1:0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (sw_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is deliberately left out of reset; stale entries are unreachable.
   always_ff @(posedge clk) begin
      if (push && !sw_rst) mem[wr_ptr] <= wdata;
   end

   assign rdata = (occupancy != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cmul_flow_ctrl.sv
// Flow controller for the complex multiplier: issue-side credit check,
// per-stage enables for the datapath and a result FIFO.
module cmul_flow_ctrl
   import cmul_pkg::*;
#(
   parameter int unsigned LATENCY   = CMUL_LATENCY,
   parameter int unsigned DEPTH     = CMUL_DEPTH,
   parameter int unsigned DATA_W    = CMUL_DATA_W,
   parameter int unsigned PIPELINED = 1
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            sw_rst,
   input  logic                            op_val,
   output logic                            op_ready,
   output logic [LATENCY-1:0]              stage_en,
   input  logic [DATA_W-1:0]               pipe_data,
   output logic                            res_val,
   input  logic                            res_ready,
   output logic [DATA_W-1:0]               res_data,
   output logic [clog2_plus1(DEPTH)-1:0]   occupancy,
   output logic                            busy
);

   localparam int unsigned IW = clog2_plus1(LATENCY);

   logic [LATENCY-1:0] vld;
   logic [IW-1:0]      inflight;
   logic               credit_ok;
   logic               accept;
   logic               push;
   logic               pop;

   assign accept = op_val && op_ready;
   assign push   = vld[LATENCY-1];
   assign pop    = res_val && res_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld <= '0;
      end else if (sw_rst) begin
         vld <= '0;
      end else begin
         vld[0] <= accept;
         for (int unsigned i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      end
   end

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY; i++) inflight = inflight + IW'(vld[i]);
   end

   // Counting in-flight slots as spent credits means a push never meets a full FIFO.
   always_comb begin
      if (PIPELINED != 0) credit_ok = (32'(occupancy) + 32'(inflight)) < DEPTH;
      else                credit_ok = (inflight == '0) && (occupancy == '0);
   end

   assign op_ready = credit_ok && !sw_rst;

   always_comb begin
      stage_en    = '0;
      stage_en[0] = accept;
      for (int unsigned i = 1; i < LATENCY; i++) stage_en[i] = vld[i-1];
   end

   assign res_val = (occupancy != '0);
   assign busy    = (|vld) || res_val;

   cmul_res_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .sw_rst    (sw_rst),
      .push      (push),
      .pop       (pop),
      .wdata     (pipe_data),
      .rdata     (res_data),
      .occupancy (occupancy)
   );

endmodule

// File: tb/tb_cmul_flow_ctrl.sv
// Scoreboard bench: a pipelined instance (LATENCY=2, DEPTH=4) and a legacy
// one-in-flight instance (LATENCY=1, PIPELINED=0) against a transaction-level model.
module tb_cmul_flow_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pipelined instance
   logic        rstn0, sw0, opv0, rr0, ordy0, rv0, busy0;
   logic [31:0] opd0, pd0, rd0;
   logic [1:0]  se0;
   logic [2:0]  occ0;
   // legacy instance
   logic        rstn1, sw1, opv1, rr1, ordy1, rv1, busy1;
   logic [31:0] opd1, pd1, rd1;
   logic [0:0]  se1;
   logic [2:0]  occ1;

   bit done0 = 0, done1 = 0;

   cmul_flow_ctrl #(.LATENCY(2), .DEPTH(4), .DATA_W(32), .PIPELINED(1)) u0 (
      .clk(clk), .rstn(rstn0), .sw_rst(sw0), .op_val(opv0), .op_ready(ordy0),
      .stage_en(se0), .pipe_data(pd0), .res_val(rv0), .res_ready(rr0),
      .res_data(rd0), .occupancy(occ0), .busy(busy0));

   cmul_flow_ctrl #(.LATENCY(1), .DEPTH(4), .DATA_W(32), .PIPELINED(0)) u1 (
      .clk(clk), .rstn(rstn1), .sw_rst(sw1), .op_val(opv1), .op_ready(ordy1),
      .stage_en(se1), .pipe_data(pd1), .res_val(rv1), .res_ready(rr1),
      .res_data(rd1), .occupancy(occ1), .busy(busy1));

   // Behavioural datapaths: operand travels through stages loaded by stage_en.
   logic [31:0] s00, s01, s10;
   always @(posedge clk) begin
      if (se0[0]) s00 <= opd0;
      if (se0[1]) s01 <= s00;
      if (se1[0]) s10 <= opd1;
   end
   assign pd0 = s01;
   assign pd1 = s10;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // Model: each accepted op becomes a buffered result at a known cycle.
   int          vis_q [2][$];
   logic [31:0] exp_q [2][$];

   task automatic model_step(input int i, input int lat, input bit pipe,
                             input logic rstn, input logic sw, input logic opv,
                             input logic rr, input logic [31:0] opd,
                             input logic ordy, input logic [1:0] se, input logic rv,
                             input logic [2:0] occ, input logic bsy);
      int         occ_m, sz;
      logic       rdy_m, rv_m;
      logic [1:0] se_m;
      if (!rstn) begin
         vis_q[i].delete();
         exp_q[i].delete();
      end
      sz    = vis_q[i].size();
      occ_m = 0;
      for (int k = 0; k < sz; k++) if (vis_q[i][k] <= cyc) occ_m++;
      rdy_m = sw ? 1'b0 : (pipe ? (sz < 4) : (sz == 0));
      rv_m  = (occ_m != 0);
      se_m  = '0;
      se_m[0] = opv && rdy_m;
      for (int j = 1; j < lat; j++)
         for (int k = 0; k < sz; k++) if (vis_q[i][k] == cyc - j + 1 + lat) se_m[j] = 1'b1;
      chk($sformatf("op_ready[%0d]", i), 32'(ordy), 32'(rdy_m));
      chk($sformatf("stage_en[%0d]", i), 32'(se), 32'(se_m));
      chk($sformatf("res_val[%0d]", i), 32'(rv), 32'(rv_m));
      chk($sformatf("occupancy[%0d]", i), 32'(occ), 32'(occ_m));
      chk($sformatf("busy[%0d]", i), 32'(bsy), 32'(sz != 0));
      if (rstn) begin
         if (sw) begin
            vis_q[i].delete();
            exp_q[i].delete();
         end else begin
            if (rv_m && rr) void'(vis_q[i].pop_front());
            if (opv && rdy_m) begin
               vis_q[i].push_back(cyc + 1 + lat);
               exp_q[i].push_back(opd);
            end
         end
      end
   endtask

   always @(posedge clk) begin
      #3;
      model_step(0, 2, 1'b1, rstn0, sw0, opv0, rr0, opd0, ordy0, se0, rv0, occ0, busy0);
      model_step(1, 1, 1'b0, rstn1, sw1, opv1, rr1, opd1, ordy1, {1'b0, se1}, rv1, occ1, busy1);
      chk("no_overflow0", 32'(u0.push && occ0 == 3'd4 && !u0.pop), 32'd0);
   end

   // Result monitor: pops the scoreboard on each consumed result.
   task automatic mon(input int i, input logic rstn, input logic sw, input logic rv,
                      input logic rr, input logic [31:0] rd);
      logic [31:0] e;
      if (!rv) chk($sformatf("res_data_idle[%0d]", i), rd, 32'd0);
      else if (rstn && !sw && rr) begin
         if (exp_q[i].size() == 0) chk($sformatf("spurious_result[%0d]", i), rd, 32'hdead_beef);
         else begin
            e = exp_q[i].pop_front();
            chk($sformatf("res_data[%0d]", i), rd, e);
         end
      end
   endtask

   always @(negedge clk) begin
      #1;
      mon(0, rstn0, sw0, rv0, rr0, rd0);
      mon(1, rstn1, sw1, rv1, rr1, rd1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [31:0] d);
      bit ok;
      ok   = 0;
      opv0 = 1'b1;
      opd0 = d;
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         if (ordy0) ok = 1;
         tick();
      end
      opv0 = 1'b0;
      chk("send0_accepted", 32'(ok), 32'd1);
   endtask

   // Pipelined instance stimulus
   initial begin
      int cnt, t0;
      rstn0 = 1'b0; sw0 = 1'b0; opv0 = 1'b0; rr0 = 1'b0; opd0 = '0;
      repeat (3) @(posedge clk);
      #1 rstn0 = 1'b1;
      tick();
      // back-to-back with consumer always ready
      rr0 = 1'b1;
      t0  = cyc;
      for (int d = 1; d <= 8; d++) send0(32'(d));
      chk("b2b_cycles", 32'(cyc - t0), 32'd8);
      repeat (6) tick();
      // backpressure: only DEPTH credits
      rr0 = 1'b0; opv0 = 1'b1; cnt = 0;
      repeat (8) begin
         opd0 = $urandom;
         #1 if (ordy0) cnt++;
         tick();
      end
      chk("bp_accepts", 32'(cnt), 32'd4);
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
         rr0  = (n == 0);
         opd0 = $urandom;
         #1 if (ordy0) cnt++;
         tick();
      end
      chk("bp_one_pop_one_accept", 32'(cnt), 32'd1);
      // steady push+pop at full, then drain
      rr0 = 1'b1;
      repeat (12) begin
         opd0 = $urandom;
         tick();
      end
      opv0 = 1'b0;
      repeat (8) tick();
      // soft reset with two in flight and two buffered
      rr0 = 1'b0;
      for (int n = 0; n < 4; n++) send0($urandom);
      sw0 = 1'b1; opv0 = 1'b1; opd0 = 32'h1234_5678;
      tick();
      sw0 = 1'b0; opv0 = 1'b0;
      repeat (3) tick();
      chk("swrst_occ", 32'(occ0), 32'd0);
      chk("swrst_busy", 32'(busy0), 32'd0);
      rr0 = 1'b1;
      send0(32'h55);
      repeat (4) tick();
      // hard reset with two results buffered
      rr0 = 1'b0;
      send0(32'hA1);
      send0(32'hA2);
      repeat (4) tick();
      chk("pre_rst_occ", 32'(occ0), 32'd2);
      rstn0 = 1'b0;
      repeat (2) tick();
      rstn0 = 1'b1;
      tick();
      #1;
      chk("rst_op_ready", 32'(ordy0), 32'd1);
      chk("rst_res_val", 32'(rv0), 32'd0);
      chk("rst_occ", 32'(occ0), 32'd0);
      chk("rst_res_data", rd0, 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      tick();
      // randomized traffic
      repeat (300) begin
         opv0 = ($urandom_range(0, 3) != 0);
         rr0  = ($urandom_range(0, 9) < 6);
         sw0  = ($urandom_range(0, 39) == 0);
         opd0 = $urandom;
         tick();
      end
      opv0 = 1'b0; sw0 = 1'b0; rr0 = 1'b1;
      repeat (8) tick();
      done0 = 1;
   end

   // Legacy instance stimulus: op_val held, consumer answers late
   initial begin
      int hi;
      rstn1 = 1'b0; sw1 = 1'b0; opv1 = 1'b0; rr1 = 1'b0; opd1 = '0;
      repeat (3) @(posedge clk);
      #1 rstn1 = 1'b1;
      tick();
      hi   = 0;
      opv1 = 1'b1;
      repeat (80) begin
         opd1 = $urandom;
         rr1  = (hi == 2);
         #1 hi = rv1 ? hi + 1 : 0;
         tick();
      end
      opv1 = 1'b0; rr1 = 1'b1;
      repeat (5) tick();
      done1 = 1;
   end

   initial begin
      wait (done0 && done1);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
